// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - dispatch/issue/flush controller for a reservation station bank
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   disp_valid          front end offers an op
//   disp_ready          bank can accept an op this cycle
//   disp_sel            one-hot free station chosen for the dispatched op
//   rs_full, rs_ready   per-station occupied / operands-resolved flags
//   fu_ready            functional unit can take an op this cycle
//   iss_valid           an op issues this cycle
//   iss_grant           one-hot station released to the FU
//   fu_done             FU retires one op this cycle
//   flush               flush request (pulse or level)
//   rs_clear            one-cycle bank-wide clear
//   inflight            outstanding FU op count
//   busy                flush sequence in progress
//   err                 sticky: retire seen with nothing in flight
module rs_issue_sched #(
    parameter int NUM_RS       = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    output logic [NUM_RS-1:0] disp_sel,
    input  logic [NUM_RS-1:0] rs_full,
    input  logic [NUM_RS-1:0] rs_ready,
    input  logic              fu_ready,
    output logic              iss_valid,
    output logic [NUM_RS-1:0] iss_grant,
    input  logic              fu_done,
    input  logic              flush,
    output logic              rs_clear,
    output logic [CNT_W-1:0]  inflight,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_RS-1:0]  free_sel;
    logic               free_hit;
    logic [NUM_RS-1:0]  cand;
    logic [NUM_RS-1:0]  grant_vec;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_hit;
    logic               run_ok;
    logic [CNT_W-1:0]   inflight_nxt;

    // Outputs are gated with rst so they read as idle while reset is held,
    // even though some of them are otherwise driven by live inputs.
    assign run_ok = ~rst & (state == S_RUN) & ~flush;

    // Lowest-index free station. A station being issued this cycle is still
    // marked full by the bank, so it is never offered for dispatch.
    always_comb begin
        free_sel = '0;
        free_hit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (!rs_full[i] && !free_hit) begin
                free_sel[i] = 1'b1;
                free_hit    = 1'b1;
            end
        end
    end

    assign disp_ready = run_ok & ~&rs_full;
    assign disp_sel   = (disp_valid && disp_ready) ? free_sel : '0;

    // Round-robin search starting at ptr and wrapping past the top index.
    assign cand = rs_ready & rs_full;

    always_comb begin
        int idx;
        grant_vec = '0;
        grant_idx = '0;
        grant_hit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_RS) idx = idx - NUM_RS;
            if (!grant_hit && cand[idx]) begin
                grant_hit      = 1'b1;
                grant_vec[idx] = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

    assign iss_valid = run_ok & fu_ready & (inflight < CNT_W'(MAX_INFLIGHT)) & grant_hit;
    assign iss_grant = iss_valid ? grant_vec : '0;

    // Simultaneous issue and retire cancel out; a retire at zero saturates.
    always_comb begin
        inflight_nxt = inflight;
        case ({iss_valid, fu_done})
            2'b10:   inflight_nxt = inflight + CNT_W'(1);
            2'b01:   inflight_nxt = (inflight == '0) ? '0 : inflight - CNT_W'(1);
            default: inflight_nxt = inflight;
        endcase
    end

    assign rs_clear = ~rst & (state == S_CLEAR);
    assign busy     = ~rst & (state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            ptr      <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            if (fu_done && inflight == '0) err <= 1'b1;
            if (iss_valid) begin
                ptr <= (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
            end
            case (state)
                S_RUN:   if (flush) state <= S_DRAIN;
                // Uses the post-retire count so the last fu_done moves us on
                // in the same cycle it arrives.
                S_DRAIN: if (inflight_nxt == '0) state <= S_CLEAR;
                S_CLEAR: state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
